// File: rtl/ram_port_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_port_initiator                                        |
// | Brief    : Drives one RAM port for a valid/ready requester and keeps |
// |            a written-address map with population count.              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ram_port_initiator #(
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_err,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    input  logic       clr_map,
    output logic [3:0] wr_count,
    output logic       full
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [8:0] c_DEPTH_LIM = 9'(DEPTH);
    localparam logic [3:0] c_DEPTH_CNT = 4'(DEPTH);
    localparam logic [1:0] c_WAIT_INIT = 2'(RD_LAT - 1);

    state_t           r_state;
    logic [1:0]       r_wait_cnt;
    logic [DEPTH-1:0] r_map;

    logic             w_hs;
    logic             w_in_range;
    logic             w_map_set;
    logic [DEPTH-1:0] w_map_next;
    logic [3:0]       w_count_next;

    assign w_hs       = req_valid && req_ready;
    assign w_in_range = {1'b0, req_addr} < c_DEPTH_LIM;
    assign w_map_set  = w_hs && req_write && w_in_range;

    // Clear is applied first so a coincident write survives it.
    always_comb begin
        w_map_next   = clr_map ? '0 : r_map;
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_map_set && (req_addr == 8'(i))) begin
                w_map_next[i] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + 4'(w_map_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_map    <= '0;
            wr_count <= '0;
            full     <= 1'b0;
        end else begin
            r_map    <= w_map_next;
            wr_count <= w_count_next;
            full     <= (w_count_next == c_DEPTH_CNT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        req_ready <= 1'b0;
                        if (!w_in_range) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else if (req_write) begin
                            r_state   <= WRITE;
                            ram_we    <= 1'b1;
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata;
                        end else begin
                            r_state  <= ISSUE;
                            ram_addr <= req_addr;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    // ram_wdata still holds the accepted write data.
                    ram_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= ram_wdata;
                    r_state    <= RESP;
                end
                ISSUE: begin
                    r_wait_cnt <= c_WAIT_INIT;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= ram_rdata;
                        r_state    <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ram_port_initiator                                     |
// | Brief    : Directed vector table, random traffic vs. reference model,|
// |            and mid-read reset sequence for ram_port_initiator.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ram_port_initiator;

    localparam int DEPTH  = 8;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'd0;
    logic [7:0] req_wdata = 8'd0;
    logic       resp_ready = 1'b0;
    logic       clr_map = 1'b0;
    logic [7:0] ram_rdata;
    logic       req_ready, resp_valid, resp_err, ram_we, full;
    logic [7:0] resp_data, ram_addr, ram_wdata;
    logic [3:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    // RAM storage; unwritten locations read back as addr ^ 8'h3C.
    logic [7:0] mem [256];
    bit         written [256];
    logic [7:0] rd_pipe [RD_LAT];

    // Reference model state.
    logic [7:0] model_mem [256];
    bit         model_written [256];
    bit         model_map [DEPTH];

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wd;
        bit         clr;
        int         stall;
        logic [7:0] exp_data;
        bit         exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    ram_port_initiator #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .clr_map    (clr_map),
        .wr_count   (wr_count),
        .full       (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we === 1'b1) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        rd_pipe[0] <= written[ram_addr] ? mem[ram_addr] : (ram_addr ^ 8'h3C);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(model_map[i]);
        return c;
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        return model_written[a] ? model_mem[a] : (a ^ 8'h3C);
    endfunction

    function automatic logic [31:0] all_outputs();
        return {req_ready, resp_valid, resp_data, resp_err, ram_we,
                ram_addr, ram_wdata, wr_count, full};
    endfunction

    // One complete transaction: handshake, observe RAM port and response,
    // optional back-pressure, response handshake, then map checks.
    task automatic do_req(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                          input bit clr, input int stall,
                          output logic [7:0] got_data, output logic got_err);
        int wt, lat, exp_lat, we_cnt;
        bit err, ram_ok, stable_ok;
        logic [7:0] exp_data;
        err      = (int'(addr) >= DEPTH);
        exp_data = err ? 8'h00 : (wr ? wd : model_rd(addr));
        exp_lat  = err ? 0 : (wr ? 1 : 1 + RD_LAT);

        wt = 0;
        while (req_ready !== 1'b1 && wt < 20) begin
            @(posedge clk); #1;
            wt++;
        end
        check("req_ready_wait", req_ready, 1);

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; clr_map = clr;
        @(posedge clk); #1;
        req_valid = 1'b0; clr_map = 1'b0;
        req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);

        if (clr) for (int i = 0; i < DEPTH; i++) model_map[i] = 1'b0;
        if (wr && !err) begin
            model_map[addr]     = 1'b1;
            model_mem[addr]     = wd;
            model_written[addr] = 1'b1;
        end

        lat = -1; we_cnt = 0; ram_ok = 1'b1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (ram_we === 1'b1) begin
                we_cnt++;
                if (ram_addr !== addr || ram_wdata !== wd) ram_ok = 1'b0;
            end
            if (!err && !wr && k <= RD_LAT && ram_addr !== addr) ram_ok = 1'b0;
            if (resp_valid === 1'b1) lat = k;
            else begin
                @(posedge clk); #1;
            end
        end
        check("resp_latency", lat, exp_lat);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, err);
        check("ram_we_cycles", we_cnt, (wr && !err) ? 1 : 0);
        check("ram_port", ram_ok, 1);
        got_data = resp_data;
        got_err  = resp_err;

        stable_ok = 1'b1;
        req_valid = (stall > 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            req_addr = 8'($urandom); req_wdata = 8'($urandom);
            if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_err !== err ||
                req_ready !== 1'b0 || ram_we !== 1'b0) stable_ok = 1'b0;
        end
        if (stall > 0) check("resp_hold", stable_ok, 1);

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; req_valid = 1'b0;
        check("resp_release", {resp_valid, req_ready}, 2'b01);
        check("wr_count", wr_count, model_count());
        check("full", full, model_count() == DEPTH);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gd;
        logic       ge;

        vecs.push_back('{1'b1, 8'd3,   8'hA5, 1'b0, 0, 8'hA5, 1'b0, 1});
        vecs.push_back('{1'b0, 8'd3,   8'h00, 1'b0, 0, 8'hA5, 1'b0, 1});
        vecs.push_back('{1'b1, 8'd9,   8'h77, 1'b0, 0, 8'h00, 1'b1, 1});
        vecs.push_back('{1'b0, 8'd9,   8'h00, 1'b0, 1, 8'h00, 1'b1, 1});
        vecs.push_back('{1'b1, 8'd0,   8'h10, 1'b0, 0, 8'h10, 1'b0, 2});
        vecs.push_back('{1'b1, 8'd1,   8'h11, 1'b0, 0, 8'h11, 1'b0, 3});
        vecs.push_back('{1'b1, 8'd2,   8'h12, 1'b0, 0, 8'h12, 1'b0, 4});
        vecs.push_back('{1'b1, 8'd3,   8'h13, 1'b0, 0, 8'h13, 1'b0, 4});
        vecs.push_back('{1'b1, 8'd4,   8'h14, 1'b0, 0, 8'h14, 1'b0, 5});
        vecs.push_back('{1'b1, 8'd5,   8'h15, 1'b0, 0, 8'h15, 1'b0, 6});
        vecs.push_back('{1'b1, 8'd6,   8'h16, 1'b0, 0, 8'h16, 1'b0, 7});
        vecs.push_back('{1'b1, 8'd7,   8'h17, 1'b0, 0, 8'h17, 1'b0, 8});
        vecs.push_back('{1'b1, 8'd2,   8'h99, 1'b0, 0, 8'h99, 1'b0, 8});
        vecs.push_back('{1'b0, 8'd2,   8'h00, 1'b0, 0, 8'h99, 1'b0, 8});
        vecs.push_back('{1'b0, 8'd6,   8'h00, 1'b0, 0, 8'h16, 1'b0, 8});
        vecs.push_back('{1'b1, 8'd5,   8'h55, 1'b1, 0, 8'h55, 1'b0, 1});
        vecs.push_back('{1'b0, 8'd5,   8'h00, 1'b0, 5, 8'h55, 1'b0, 1});
        vecs.push_back('{1'b1, 8'd200, 8'h3E, 1'b0, 2, 8'h00, 1'b1, 1});
        vecs.push_back('{1'b0, 8'd0,   8'h00, 1'b0, 0, 8'h10, 1'b0, 1});

        // Reset state, then first cycle after release.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", req_ready, 1);

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].clr, vecs[i].stall, gd, ge);
            check($sformatf("vec%0d_data", i), gd, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), ge, vecs[i].exp_err);
            check($sformatf("vec%0d_count", i), wr_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_full", i), full, vecs[i].exp_cnt == DEPTH);
        end

        for (int n = 0; n < 120; n++) begin
            do_req(1'($urandom), 8'($urandom_range(0, 11)), 8'($urandom),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)), gd, ge);
        end

        // Reset asserted while a read sits in WAIT.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd4; clr_map = 1'b0;
        check("pre_reset_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 0);
        for (int i = 0; i < DEPTH; i++) model_map[i] = 1'b0;
        @(posedge clk); #1;
        check("no_resp_in_reset", resp_valid, 0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("after_release", {resp_valid, req_ready}, 2'b01);
        check("map_after_reset", wr_count, model_count());
        do_req(1'b0, 8'd4, 8'h00, 1'b0, 0, gd, ge);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
